// File: rtl/mul_mac_seq_pkg.sv
// Shared definitions for the multiply-accumulate sequencer: FSM states and
// the multiplier class / result-select encodings driven on ps_mul_cls/sc.
package mul_mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC  = 3'd1,
        SAT  = 3'd2,
        RD0  = 3'd3,
        RD1  = 3'd4,
        RD2  = 3'd5,
        RDW  = 3'd6,
        DONE = 3'd7
    } state_e;

    // Multiplier operation class
    localparam logic [1:0] CLS_MR   = 2'b00;  // MR access (read or saturate)
    localparam logic [1:0] CLS_PROD = 2'b01;  // MR = x*y
    localparam logic [1:0] CLS_ACC  = 2'b10;  // MR = MR + x*y
    localparam logic [1:0] CLS_SUB  = 2'b11;  // MR = MR - x*y

    // MR slice select / saturate command
    localparam logic [1:0] SC_MR0 = 2'b00;
    localparam logic [1:0] SC_MR1 = 2'b01;
    localparam logic [1:0] SC_MR2 = 2'b10;
    localparam logic [1:0] SC_SAT = 2'b11;

endpackage

// File: rtl/mul_mac_seq.sv
// Sequencer that streams len operand pairs into an external multiplier as a
// multiply-accumulate job, optionally saturates MR, then reads MR0..MR2 back.
//
// Operand handshake: a pair moves when opnd_valid and opnd_ready are both 1
// on a rising clk edge. opnd_ready is 1 only in MAC and never in an abort
// cycle; the source may hold opnd_valid low to stall (MR is held meanwhile).
module mul_mac_seq
    import mul_mac_seq_pkg::*;
#(
    parameter int RF_DATASIZE = 16,
    parameter int LEN_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_W-1:0]       len,
    input  logic [3:0]             dtsts,
    input  logic                   sub,
    input  logic                   sat,
    input  logic                   opnd_valid,
    output logic                   opnd_ready,
    input  logic [RF_DATASIZE-1:0] opnd_x,
    input  logic [RF_DATASIZE-1:0] opnd_y,
    output logic                   ps_mul_en,
    output logic                   ps_mul_otreg,
    output logic [3:0]             ps_mul_dtsts,
    output logic [1:0]             ps_mul_cls,
    output logic [1:0]             ps_mul_sc,
    output logic [RF_DATASIZE-1:0] xb_dtx,
    output logic [RF_DATASIZE-1:0] xb_dty,
    input  logic [RF_DATASIZE-1:0] mul_xb_dt,
    input  logic                   mul_ps_mv,
    input  logic                   mul_ps_mn,
    output logic                   busy,
    output logic                   done,
    output logic [RF_DATASIZE-1:0] result0,
    output logic [RF_DATASIZE-1:0] result1,
    output logic [RF_DATASIZE-1:0] result2,
    output logic                   mv_sticky,
    output logic                   mn_last,
    output logic [2:0]             dbg_state
);

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       cnt_q;
    logic [LEN_W-1:0]       len_q;
    logic [3:0]             dtsts_q;
    logic                   sub_q;
    logic                   sat_q;
    logic                   issue_q;
    logic                   mv_sticky_q;
    logic                   mn_last_q;
    logic [RF_DATASIZE-1:0] result0_q, result1_q, result2_q;

    logic                   xfer;
    logic                   sat_issue;
    logic [LEN_W-1:0]       last_idx;

    // Index of the final pair; only meaningful in MAC where len_q >= 1
    assign last_idx = len_q - LEN_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and multiplier command decode; abort overrides everything
    always_comb begin
        state_d      = state_q;
        opnd_ready   = 1'b0;
        xfer         = 1'b0;
        sat_issue    = 1'b0;
        ps_mul_en    = 1'b0;
        ps_mul_otreg = 1'b0;
        ps_mul_dtsts = '0;
        ps_mul_cls   = CLS_MR;
        ps_mul_sc    = SC_MR0;
        xb_dtx       = '0;
        xb_dty       = '0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len == '0) ? DONE : MAC;
            end
            MAC: begin
                opnd_ready = 1'b1;
                if (opnd_valid) begin
                    xfer         = 1'b1;
                    ps_mul_en    = 1'b1;
                    ps_mul_otreg = 1'b1;
                    ps_mul_dtsts = dtsts_q;
                    ps_mul_cls   = (cnt_q == '0) ? CLS_PROD : (sub_q ? CLS_SUB : CLS_ACC);
                    xb_dtx       = opnd_x;
                    xb_dty       = opnd_y;
                    if (cnt_q == last_idx) state_d = sat_q ? SAT : RD0;
                end
            end
            SAT: begin
                sat_issue    = 1'b1;
                ps_mul_en    = 1'b1;
                ps_mul_otreg = 1'b1;
                ps_mul_dtsts = dtsts_q;
                ps_mul_sc    = SC_SAT;
                state_d      = RD0;
            end
            RD0: begin
                ps_mul_en    = 1'b1;
                ps_mul_dtsts = dtsts_q;
                ps_mul_sc    = SC_MR0;
                state_d      = RD1;
            end
            RD1: begin
                ps_mul_en    = 1'b1;
                ps_mul_dtsts = dtsts_q;
                ps_mul_sc    = SC_MR1;
                state_d      = RD2;
            end
            RD2: begin
                ps_mul_en    = 1'b1;
                ps_mul_dtsts = dtsts_q;
                ps_mul_sc    = SC_MR2;
                state_d      = RDW;
            end
            RDW:  state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            opnd_ready   = 1'b0;
            xfer         = 1'b0;
            sat_issue    = 1'b0;
            ps_mul_en    = 1'b0;
            ps_mul_otreg = 1'b0;
            ps_mul_dtsts = '0;
            ps_mul_cls   = CLS_MR;
            ps_mul_sc    = SC_MR0;
            xb_dtx       = '0;
            xb_dty       = '0;
            done         = 1'b0;
        end
    end

    // Command latch, pair counter, multiplier flag capture and readback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            len_q       <= '0;
            dtsts_q     <= '0;
            sub_q       <= 1'b0;
            sat_q       <= 1'b0;
            issue_q     <= 1'b0;
            mv_sticky_q <= 1'b0;
            mn_last_q   <= 1'b0;
            result0_q   <= '0;
            result1_q   <= '0;
            result2_q   <= '0;
        end else begin
            // Multiplier flags arrive one cycle after the op that set them
            issue_q <= xfer | sat_issue;
            if ((state_q == IDLE) && start) begin
                len_q       <= len;
                dtsts_q     <= dtsts;
                sub_q       <= sub;
                sat_q       <= sat;
                cnt_q       <= '0;
                mv_sticky_q <= 1'b0;
                result0_q   <= '0;
                result1_q   <= '0;
                result2_q   <= '0;
            end else begin
                if (xfer) cnt_q <= cnt_q + LEN_W'(1);
                if (issue_q) begin
                    mv_sticky_q <= mv_sticky_q | mul_ps_mv;
                    mn_last_q   <= mul_ps_mn;
                end
                // Read data lags the RDx issue by one cycle
                if (state_q == RD1) result0_q <= mul_xb_dt;
                if (state_q == RD2) result1_q <= mul_xb_dt;
                if (state_q == RDW) result2_q <= mul_xb_dt;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign result0   = result0_q;
    assign result1   = result1_q;
    assign result2   = result2_q;
    assign mv_sticky = mv_sticky_q;
    assign mn_last   = mn_last_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_mac_seq.sv
// Bench for mul_mac_seq: a behavioural 48-bit MR multiplier sits beside the
// sequencer, and each job is checked against an arithmetic reference.
module tb_mul_mac_seq;
    import mul_mac_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start = 0, abort = 0, sub = 0, sat = 0, opnd_valid = 0;
    logic [3:0]  len = 0, dtsts = 0;
    logic [15:0] opnd_x = 0, opnd_y = 0;
    logic        opnd_ready, ps_mul_en, ps_mul_otreg;
    logic [3:0]  ps_mul_dtsts;
    logic [1:0]  ps_mul_cls, ps_mul_sc;
    logic [15:0] xb_dtx, xb_dty, mul_xb_dt;
    logic        mul_ps_mv, mul_ps_mn;
    logic        busy, done, mv_sticky, mn_last;
    logic [15:0] result0, result1, result2;
    logic [2:0]  dbg_state;

    mul_mac_seq #(.RF_DATASIZE(16), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
        .dtsts(dtsts), .sub(sub), .sat(sat), .opnd_valid(opnd_valid),
        .opnd_ready(opnd_ready), .opnd_x(opnd_x), .opnd_y(opnd_y),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
        .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
        .xb_dtx(xb_dtx), .xb_dty(xb_dty), .mul_xb_dt(mul_xb_dt),
        .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn), .busy(busy), .done(done),
        .result0(result0), .result1(result1), .result2(result2),
        .mv_sticky(mv_sticky), .mn_last(mn_last), .dbg_state(dbg_state)
    );

    // ---------------- neighbouring multiplier (unsigned integer MR) ----------------
    logic [47:0] mr;
    always @(posedge clk or negedge reset) begin : mult_model
        logic [47:0] p, n;
        if (!reset) begin
            mr <= '0; mul_xb_dt <= '0; mul_ps_mv <= 1'b0; mul_ps_mn <= 1'b0;
        end else if (ps_mul_en) begin
            p = 48'(xb_dtx) * 48'(xb_dty);
            n = mr;
            case (ps_mul_cls)
                CLS_PROD: n = p;
                CLS_ACC:  n = mr + p;
                CLS_SUB:  n = mr - p;
                default:  if (ps_mul_sc == SC_SAT) n = (mr > 48'hFFFF) ? 48'hFFFF : mr;
            endcase
            if (ps_mul_otreg) begin
                mr <= n; mul_ps_mv <= (n > 48'hFFFF); mul_ps_mn <= n[47];
            end else begin
                case (ps_mul_sc)
                    SC_MR0:  mul_xb_dt <= mr[15:0];
                    SC_MR1:  mul_xb_dt <= mr[31:16];
                    SC_MR2:  mul_xb_dt <= mr[47:32];
                    default: mul_xb_dt <= '0;
                endcase
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] xs[16];
    logic [15:0] ys[16];

    // Reference: sum of (signed by sub) products, optional clamp to one word
    task automatic ref_model(input int n, input logic sb, input logic st,
                             output logic [15:0] r0, output logic [15:0] r1,
                             output logic [15:0] r2, output logic mv, output logic mn);
        logic [47:0] acc, p;
        acc = '0; mv = 1'b0; mn = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = 48'(xs[i]) * 48'(ys[i]);
            if (i == 0)  acc = p;
            else if (sb) acc = acc - p;
            else         acc = acc + p;
            mv = mv | (acc > 48'hFFFF);
            mn = acc[47];
        end
        if (st && n > 0) begin
            if (acc > 48'hFFFF) acc = 48'hFFFF;
            mn = acc[47];
        end
        r0 = acc[15:0]; r1 = acc[31:16]; r2 = acc[47:32];
    endtask

    // ---------------- driver: one complete job ----------------
    task automatic run_job(input int len_i, input logic [3:0] dts, input logic sb,
                           input logic st, input int stall_n, input bit rand_gap,
                           input bit busy_poke);
        int k, cyc, stalls, done_cyc, reads, sats, stall_left, exp_cyc;
        bit go;
        logic [1:0] exp_cls;
        logic [15:0] e0, e1, e2;
        logic emv, emn;
        ref_model(len_i, sb, st, e0, e1, e2, emv, emn);
        @(negedge clk);
        start = 1'b1; len = 4'(len_i); dtsts = dts; sub = sb; sat = st; opnd_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_before_start: busy=%b want 0", busy); end
        k = 0; cyc = 0; stalls = 0; done_cyc = -1; reads = 0; sats = 0; stall_left = stall_n;
        while (cyc < 300 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            len = 4'($urandom_range(15)); dtsts = 4'($urandom_range(15));
            sub = 1'($urandom_range(1)); sat = 1'($urandom_range(1));
            go = 1'b0;
            if (k < len_i) begin
                if (k > 0 && stall_left > 0) stall_left--;
                else if (k > 0 && rand_gap && $urandom_range(3) == 0) go = 1'b0;
                else go = 1'b1;
            end
            opnd_valid = go;
            opnd_x = go ? xs[k] : 16'($urandom);
            opnd_y = go ? ys[k] : 16'($urandom);
            if (!go && k > 0 && k < len_i && busy_poke) begin
                start = 1'b1; len = 4'($urandom_range(1, 15)); dtsts = ~dts; sub = ~sb; sat = ~st;
            end
            #1;
            if (go) begin
                exp_cls = (k == 0) ? CLS_PROD : (sb ? CLS_SUB : CLS_ACC);
                n_checks++;
                if (opnd_ready !== 1'b1 || ps_mul_en !== 1'b1 || ps_mul_otreg !== 1'b1) begin
                    n_fail++;
                    $display("FAIL xfer_ctrl pair %0d: ready=%b en=%b otreg=%b want 1 1 1", k, opnd_ready, ps_mul_en, ps_mul_otreg);
                end
                n_checks++;
                if (ps_mul_cls !== exp_cls || ps_mul_dtsts !== dts) begin
                    n_fail++;
                    $display("FAIL xfer_cls pair %0d: cls=%b dtsts=%b want cls=%b dtsts=%b", k, ps_mul_cls, ps_mul_dtsts, exp_cls, dts);
                end
                n_checks++;
                if (xb_dtx !== xs[k] || xb_dty !== ys[k]) begin
                    n_fail++;
                    $display("FAIL xfer_data pair %0d: x=%h y=%h want x=%h y=%h", k, xb_dtx, xb_dty, xs[k], ys[k]);
                end
                k++;
            end else if (k > 0 && k < len_i) begin
                stalls++;
                n_checks++;
                if (ps_mul_en !== 1'b0 || opnd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall: en=%b ready=%b want en=0 ready=1", ps_mul_en, opnd_ready);
                end
            end else if (ps_mul_en === 1'b1) begin
                if (ps_mul_cls == CLS_MR && ps_mul_otreg == 1'b0) begin
                    reads++;
                    n_checks++;
                    if (xb_dtx !== 16'h0 || ps_mul_sc !== 2'(reads - 1)) begin
                        n_fail++;
                        $display("FAIL read_issue %0d: xb_dtx=%h sc=%b want 0000 sc=%0d", reads, xb_dtx, ps_mul_sc, reads - 1);
                    end
                end else if (ps_mul_cls == CLS_MR && ps_mul_sc == SC_SAT) begin
                    sats++;
                end
            end
            if (ps_mul_en === 1'b0) begin
                n_checks++;
                if (ps_mul_otreg !== 1'b0 || ps_mul_cls !== 2'b00 || ps_mul_sc !== 2'b00 ||
                    ps_mul_dtsts !== 4'h0 || xb_dtx !== 16'h0 || xb_dty !== 16'h0) begin
                    n_fail++;
                    $display("FAIL idle_ctrl: otreg=%b cls=%b sc=%b dtsts=%h x=%h y=%h want all 0",
                             ps_mul_otreg, ps_mul_cls, ps_mul_sc, ps_mul_dtsts, xb_dtx, xb_dty);
                end
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        start = 1'b0; opnd_valid = 1'b0;
        exp_cyc = (len_i == 0) ? 1 : (len_i + stalls + (st ? 1 : 0) + 5);
        n_checks++;
        if (done_cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL done_time len=%0d: done at cycle %0d want %0d", len_i, done_cyc, exp_cyc);
        end
        if (done_cyc >= 0) begin
            n_checks++;
            if (reads != ((len_i > 0) ? 3 : 0) || sats != ((st && len_i > 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL issue_count: reads=%0d sats=%0d want %0d %0d", reads, sats,
                         (len_i > 0) ? 3 : 0, (st && len_i > 0) ? 1 : 0);
            end
            n_checks++;
            if (result0 !== e0 || result1 !== e1 || result2 !== e2) begin
                n_fail++;
                $display("FAIL results: got %h %h %h want %h %h %h", result0, result1, result2, e0, e1, e2);
            end
            n_checks++;
            if (mv_sticky !== emv || (len_i > 0 && mn_last !== emn) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL flags: mv=%b mn=%b busy=%b want mv=%b mn=%b busy=1", mv_sticky, mn_last, busy, emv, emn);
            end
            @(negedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result0 !== e0 || result1 !== e1 || result2 !== e2) begin
                n_fail++;
                $display("FAIL after_done: done=%b busy=%b r0=%h want done=0 busy=0 r0=%h", done, busy, result0, e0);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 0 || done !== 0 || opnd_ready !== 0 || ps_mul_en !== 0 || mv_sticky !== 0 ||
            mn_last !== 0 || result0 !== 0 || result1 !== 0 || result2 !== 0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b rdy=%b en=%b mv=%b mn=%b r=%h/%h/%h want all 0",
                     busy, done, opnd_ready, ps_mul_en, mv_sticky, mn_last, result0, result1, result2);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        xs[0] = 2; xs[1] = 3; xs[2] = 4; ys[0] = 5; ys[1] = 6; ys[2] = 7;
        run_job(3, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_sub;
        xs[0] = 100; xs[1] = 30; ys[0] = 1; ys[1] = 1;
        run_job(2, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        xs[0] = 16'hFFFF; ys[0] = 16'hFFFF;
        run_job(1, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        xs[0] = 2; xs[1] = 3; xs[2] = 4; ys[0] = 5; ys[1] = 6; ys[2] = 7;
        run_job(3, 4'b0000, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_saturate;
        xs[0] = 16'h1234; xs[1] = 16'hFFFF; ys[0] = 16'h0010; ys[1] = 16'h0003;
        run_job(2, 4'b0101, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        int done_seen;
        xs[0] = 7; ys[0] = 9;
        @(negedge clk);
        start = 1'b1; len = 4'd3; dtsts = 4'h0; sub = 1'b0; sat = 1'b0;
        @(negedge clk);
        start = 1'b0; opnd_valid = 1'b1; opnd_x = 16'd7; opnd_y = 16'd9;
        @(negedge clk);
        abort = 1'b1; opnd_x = 16'd11; opnd_y = 16'd13;
        #1;
        n_checks++;
        if (ps_mul_en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cycle: en=%b done=%b want 0 0", ps_mul_en, done);
        end
        @(negedge clk);
        abort = 1'b0; opnd_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: busy=%b want 0", busy); end
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: done pulses=%0d want 0", done_seen); end
        run_job(0, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_start;
        xs[0] = 16'h0101; xs[1] = 16'h0033; xs[2] = 16'h0002; ys[0] = 16'h0020; ys[1] = 16'h0004; ys[2] = 16'h0100;
        run_job(3, 4'b1010, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_max_len;
        for (int i = 0; i < 16; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
        run_job(15, 4'b0011, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 16; i++) begin
                xs[i] = 16'($urandom_range(0, (j % 2 == 0) ? 255 : 65535));
                ys[i] = 16'($urandom_range(0, (j % 2 == 0) ? 255 : 65535));
            end
            run_job($urandom_range(1, 15), 4'($urandom_range(15)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 0, 1'b1, 1'($urandom_range(1)));
        end
    endtask

    task automatic test_reset_mid_job;
        int done_seen;
        @(negedge clk);
        start = 1'b1; len = 4'd4; dtsts = 4'h0; sub = 1'b0; sat = 1'b0;
        @(negedge clk);
        start = 1'b0; opnd_valid = 1'b1; opnd_x = 16'h00FF; opnd_y = 16'h0100;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 0 || opnd_ready !== 0 || ps_mul_en !== 0 || done !== 0 ||
            mv_sticky !== 0 || result0 !== 0 || result1 !== 0 || result2 !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_job: busy=%b rdy=%b en=%b done=%b mv=%b r0=%h want all 0",
                     busy, opnd_ready, ps_mul_en, done, mv_sticky, result0);
        end
        opnd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin n_fail++; $display("FAIL reset_no_done: active cycles=%0d want 0", done_seen); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_overflow();
        test_stall();
        test_saturate();
        test_abort();
        test_busy_start();
        test_max_len();
        test_random();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
